// File: rtl/wb_daq_dma_writer_pkg.sv
// rtl/wb_daq_dma_writer_pkg.sv - shared encodings for the DAQ Wishbone write engine
//
// Purpose: FSM state encoding and fixed Wishbone sideband values used by
//          wb_daq_dma_writer.
// Ports:   none (package).

package wb_daq_dma_writer_pkg;

  typedef enum logic [2:0] {
    DMA_IDLE  = 3'd0,
    DMA_POP   = 3'd1,
    DMA_LOAD  = 3'd2,
    DMA_WRITE = 3'd3,
    DMA_DONE  = 3'd4
  } dma_state_e;

  localparam logic [2:0] CTI_CLASSIC       = 3'b000;
  localparam logic [1:0] BTE_LINEAR        = 2'b00;
  localparam logic [3:0] SEL_ALL           = 4'hF;
  localparam int         MAX_RETRY_DEFAULT = 15;

endpackage

// File: rtl/wb_daq_dma_writer.sv
// rtl/wb_daq_dma_writer.sv - Wishbone master that drains the sample FIFO into SRAM
//
// Purpose: pops ADC samples from a synchronous FIFO and writes each one as a
//          single classic Wishbone write to a contiguous word-aligned buffer.
// Ports:
//   wb_clk, wb_rst         clock, synchronous active-high reset
//   start, abort           1-cycle start pulse, level abort request
//   base_adr, num_words    transfer parameters latched on an accepted start
//   fifo_dat/empty/rd      sample FIFO read side (data valid 1 cycle after rd)
//   wb_*_o / wb_*_i        Wishbone classic master interface
//   busy, done, error      status (done is a 1-cycle pulse, error is sticky)
//   words_written          acked words in the current/last transfer

module wb_daq_dma_writer
  import wb_daq_dma_writer_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int CW        = 16,
  parameter int MAX_RETRY = MAX_RETRY_DEFAULT
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] base_adr,
  input  logic [CW-1:0] num_words,
  input  logic [DW-1:0] fifo_dat,
  input  logic          fifo_empty,
  output logic          fifo_rd,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [CW-1:0] words_written
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RTY_LIMIT = RW'(MAX_RETRY);

  dma_state_e    state_q;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] dat_q;
  logic [CW-1:0] remaining_q;
  logic [CW-1:0] words_q;
  logic [RW-1:0] retry_q;
  logic          cyc_q;
  logic          fifo_rd_q;
  logic          busy_q;
  logic          done_q;
  logic          error_q;

  logic [AW-1:0] adr_next_d;
  logic [AW-1:0] base_aligned_d;

  assign adr_next_d     = adr_q + AW'(4);
  assign base_aligned_d = base_adr & ~AW'(3);

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q     <= DMA_IDLE;
      adr_q       <= '0;
      dat_q       <= '0;
      remaining_q <= '0;
      words_q     <= '0;
      retry_q     <= '0;
      cyc_q       <= 1'b0;
      fifo_rd_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      // Pulse outputs default low so each is high for exactly one cycle.
      done_q    <= 1'b0;
      fifo_rd_q <= 1'b0;

      case (state_q)
        DMA_IDLE: begin
          if (start) begin
            busy_q      <= 1'b1;
            error_q     <= 1'b0;
            words_q     <= '0;
            retry_q     <= '0;
            adr_q       <= base_aligned_d;
            remaining_q <= num_words;
            if (num_words == '0) begin
              state_q <= DMA_DONE;
            end else if (!fifo_empty && !abort) begin
              // Collapse the first POP into the start cycle so the first
              // strobe appears three cycles after start.
              fifo_rd_q <= 1'b1;
              state_q   <= DMA_LOAD;
            end else begin
              state_q <= DMA_POP;
            end
          end
        end

        DMA_POP: begin
          if (abort) begin
            state_q <= DMA_DONE;
          end else if (!fifo_empty) begin
            fifo_rd_q <= 1'b1;
            state_q   <= DMA_LOAD;
          end
        end

        DMA_LOAD: begin
          // First LOAD cycle carries the pop strobe; the FIFO data is valid
          // in the second, where it is captured and the cycle is opened.
          if (!fifo_rd_q) begin
            dat_q   <= fifo_dat;
            cyc_q   <= 1'b1;
            state_q <= DMA_WRITE;
          end
        end

        DMA_WRITE: begin
          if (cyc_q) begin
            if (wb_err_i) begin
              cyc_q   <= 1'b0;
              error_q <= 1'b1;
              state_q <= DMA_DONE;
            end else if (wb_rty_i) begin
              cyc_q <= 1'b0;
              if (retry_q == RTY_LIMIT) begin
                error_q <= 1'b1;
                state_q <= DMA_DONE;
              end else begin
                retry_q <= retry_q + RW'(1);
              end
            end else if (wb_ack_i) begin
              cyc_q       <= 1'b0;
              adr_q       <= adr_next_d;
              words_q     <= words_q + CW'(1);
              remaining_q <= remaining_q - CW'(1);
              retry_q     <= '0;
              if (remaining_q == CW'(1) || abort) begin
                state_q <= DMA_DONE;
              end else begin
                state_q <= DMA_POP;
              end
            end
          end else begin
            // One idle cycle after a retry; reissue the same address/data.
            cyc_q <= 1'b1;
          end
        end

        DMA_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DMA_IDLE;
        end

        default: begin
          cyc_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= DMA_IDLE;
        end
      endcase
    end
  end

  assign fifo_rd       = fifo_rd_q;
  assign wb_adr_o      = adr_q;
  assign wb_dat_o      = dat_q;
  assign wb_sel_o      = cyc_q ? SEL_ALL : 4'h0;
  assign wb_we_o       = cyc_q;
  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = cyc_q;
  assign wb_cti_o      = CTI_CLASSIC;
  assign wb_bte_o      = BTE_LINEAR;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_wb_daq_dma_writer.sv
// tb/tb_wb_daq_dma_writer.sv - self-checking bench for wb_daq_dma_writer

module tb_wb_daq_dma_writer;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] base_adr = '0;
  logic [15:0] num_words = '0;
  logic [31:0] fifo_dat = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        wb_ack_i, wb_err_i, wb_rty_i;
  logic        busy, done, error;
  logic [15:0] words_written;

  always #5 wb_clk = ~wb_clk;

  wb_daq_dma_writer dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .start(start), .abort(abort),
    .base_adr(base_adr), .num_words(num_words), .fifo_dat(fifo_dat),
    .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o),
    .wb_bte_o(wb_bte_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i), .busy(busy), .done(done), .error(error),
    .words_written(words_written)
  );

  // Slave response per bus attempt, encoded {err, rty, ack}.
  localparam logic [2:0] R_ACK = 3'b001;
  localparam logic [2:0] R_RTY = 3'b010;
  localparam logic [2:0] R_ERR = 3'b100;

  logic [2:0]  cur_resp = R_ACK;
  logic        consumed = 1'b0;
  logic        stall = 1'b0;
  logic        prev_cyc = 1'b0;
  logic [31:0] fifo_mem[$];
  logic [2:0]  resp_mem[$];
  logic [31:0] log_adr[$];
  logic [31:0] log_dat[$];
  int          rise_t[$];
  int          cyc_cnt = 0;
  int          n_rd = 0;
  int          n_done = 0;
  int          done_t = 0;
  int          bad_attr = 0;
  logic        cyc_seen = 1'b0;

  int n_total = 0;
  int n_pass  = 0;

  assign wb_ack_i = wb_cyc_o & wb_stb_o & cur_resp[0];
  assign wb_rty_i = wb_cyc_o & wb_stb_o & cur_resp[1];
  assign wb_err_i = wb_cyc_o & wb_stb_o & cur_resp[2];

  // FIFO model, bus slave and monitor, all evaluated on the falling edge.
  always @(negedge wb_clk) begin
    cyc_cnt = cyc_cnt + 1;
    if (fifo_rd) begin
      n_rd = n_rd + 1;
      if (fifo_mem.size() > 0) fifo_dat = fifo_mem.pop_front();
    end
    fifo_empty = stall || (fifo_mem.size() == 0);
    if (wb_cyc_o && !prev_cyc) rise_t.push_back(cyc_cnt);
    if (wb_cyc_o) begin
      cyc_seen = 1'b1;
      log_adr.push_back(wb_adr_o);
      log_dat.push_back(wb_dat_o);
      if (wb_sel_o != 4'hF || !wb_we_o || !wb_stb_o || wb_cti_o != 3'b000 || wb_bte_o != 2'b00)
        bad_attr = bad_attr + 1;
      consumed = 1'b1;
    end else if (consumed) begin
      consumed = 1'b0;
      cur_resp = (resp_mem.size() > 0) ? resp_mem.pop_front() : R_ACK;
    end
    if (done) begin
      n_done = n_done + 1;
      done_t = cyc_cnt;
    end
    prev_cyc = wb_cyc_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total = n_total + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(negedge wb_clk);
    #1;
  endtask

  task automatic clear_all();
    fifo_mem.delete(); resp_mem.delete(); log_adr.delete(); log_dat.delete();
    rise_t.delete();
    n_rd = 0; n_done = 0; cyc_seen = 1'b0; bad_attr = 0;
    cur_resp = R_ACK; consumed = 1'b0; stall = 1'b0;
  endtask

  task automatic load_fifo(input logic [31:0] d0, input int n);
    for (int i = 0; i < n; i++) fifo_mem.push_back(d0 + 32'(i));
    step();
  endtask

  // Raise start for one cycle; returns the negedge index at which it was raised.
  task automatic pulse_start(input logic [31:0] b, input int n, output int t0);
    base_adr = b; num_words = 16'(n); start = 1'b1; t0 = cyc_cnt;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin step(); k++; end
    if (n_done == 0) check({name, "_timeout"}, 32'd0, 32'd1);
    repeat (3) step();
  endtask

  typedef struct {
    logic [31:0] base;
    int          n;
    logic [31:0] d0;
    logic [31:0] exp_adr0;
  } vec_t;

  vec_t vecs[4];
  int   t0;
  int   cnt104;

  initial begin
    vecs[0] = '{base: 32'h0000_0100, n: 4, d0: 32'hA0, exp_adr0: 32'h0000_0100};
    vecs[1] = '{base: 32'h0000_0103, n: 3, d0: 32'h5555_0000, exp_adr0: 32'h0000_0100};
    vecs[2] = '{base: 32'hFFFF_FFF9, n: 4, d0: 32'hDEAD_0000, exp_adr0: 32'hFFFF_FFF8};
    vecs[3] = '{base: 32'h0000_2002, n: 1, d0: 32'h1234_5678, exp_adr0: 32'h0000_2000};

    repeat (3) step();
    wb_rst = 1'b0;
    step();
    check("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_words", {16'd0, words_written}, 32'd0);
    check("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);

    // Table of normal transfers with zero-wait ack.
    for (int v = 0; v < 4; v++) begin
      clear_all();
      load_fifo(vecs[v].d0, vecs[v].n);
      pulse_start(vecs[v].base, vecs[v].n, t0);
      wait_done($sformatf("vec%0d", v), 200);
      check($sformatf("vec%0d_nwrites", v), 32'(log_adr.size()), 32'(vecs[v].n));
      for (int i = 0; i < vecs[v].n && i < log_adr.size(); i++) begin
        check($sformatf("vec%0d_adr%0d", v, i), log_adr[i], vecs[v].exp_adr0 + 32'(4 * i));
        check($sformatf("vec%0d_dat%0d", v, i), log_dat[i], vecs[v].d0 + 32'(i));
      end
      check($sformatf("vec%0d_words", v), {16'd0, words_written}, 32'(vecs[v].n));
      check($sformatf("vec%0d_error", v), {31'd0, error}, 32'd0);
      check($sformatf("vec%0d_ndone", v), 32'(n_done), 32'd1);
      check($sformatf("vec%0d_npop", v), 32'(n_rd), 32'(vecs[v].n));
      check($sformatf("vec%0d_attr", v), 32'(bad_attr), 32'd0);
      if (v == 0) begin
        check("lat_first_stb", 32'(rise_t[0] - t0), 32'd3);
        check("throughput", 32'(rise_t[1] - rise_t[0]), 32'd4);
        check("busy_after", {31'd0, busy}, 32'd0);
      end
    end

    // n = 0: done two cycles after start, no pop, no bus cycle.
    clear_all();
    pulse_start(32'h400, 0, t0);
    check("n0_busy", {31'd0, busy}, 32'd1);
    wait_done("n0", 20);
    check("n0_done_lat", 32'(done_t - t0), 32'd2);
    check("n0_cyc", {31'd0, cyc_seen}, 32'd0);
    check("n0_pop", 32'(n_rd), 32'd0);

    // FIFO runs dry for 10+ cycles mid-transfer.
    clear_all();
    load_fifo(32'hC0, 2);
    pulse_start(32'h800, 4, t0);
    repeat (15) step();
    begin
      int bad = 0;
      for (int i = 0; i < 10; i++) begin
        if (wb_cyc_o || !busy) bad++;
        step();
      end
      check("stall_idle", 32'(bad), 32'd0);
    end
    fifo_mem.push_back(32'hC2); fifo_mem.push_back(32'hC3);
    wait_done("stall", 200);
    check("stall_nwrites", 32'(log_dat.size()), 32'd4);
    for (int i = 0; i < 4 && i < log_dat.size(); i++)
      check($sformatf("stall_dat%0d", i), log_dat[i], 32'hC0 + 32'(i));

    // Two retries on word 1, then ack.
    clear_all();
    resp_mem = '{R_RTY, R_RTY, R_ACK, R_ACK, R_ACK};
    load_fifo(32'hB0, 4);
    pulse_start(32'h100, 4, t0);
    wait_done("rty2", 200);
    cnt104 = 0;
    foreach (log_adr[i]) if (log_adr[i] == 32'h104) cnt104++;
    check("rty2_adr104", 32'(cnt104), 32'd3);
    check("rty2_pops", 32'(n_rd), 32'd4);
    check("rty2_error", {31'd0, error}, 32'd0);
    check("rty2_words", {16'd0, words_written}, 32'd4);
    check("rty2_gap", 32'(rise_t[2] - rise_t[1]), 32'd2);
    check("rty2_dat", log_dat[3], 32'hB1);

    // Sixteen consecutive retries become an error.
    clear_all();
    cur_resp = R_RTY;
    repeat (15) resp_mem.push_back(R_RTY);
    load_fifo(32'hE0, 1);
    pulse_start(32'h200, 1, t0);
    wait_done("rty16", 300);
    check("rty16_error", {31'd0, error}, 32'd1);
    check("rty16_attempts", 32'(log_adr.size()), 32'd16);
    check("rty16_words", {16'd0, words_written}, 32'd0);
    check("rty16_ndone", 32'(n_done), 32'd1);

    // Error on word 2.
    clear_all();
    resp_mem = '{R_ACK, R_ERR};
    load_fifo(32'hF0, 4);
    pulse_start(32'h300, 4, t0);
    wait_done("err", 200);
    check("err_error", {31'd0, error}, 32'd1);
    check("err_words", {16'd0, words_written}, 32'd2);
    check("err_ndone", 32'(n_done), 32'd1);
    check("err_pops", 32'(n_rd), 32'd3);

    // Next start clears the sticky error.
    clear_all();
    load_fifo(32'h11, 1);
    pulse_start(32'h300, 1, t0);
    check("clr_error", {31'd0, error}, 32'd0);
    wait_done("clr", 100);
    check("clr_words", {16'd0, words_written}, 32'd1);

    // Simultaneous responses: rty beats ack, err beats everything.
    clear_all();
    resp_mem = '{R_ACK, 3'b111};
    cur_resp = 3'b011;
    load_fifo(32'h70, 2);
    pulse_start(32'h500, 2, t0);
    wait_done("prio", 200);
    check("prio_attempts", 32'(log_adr.size()), 32'd3);
    check("prio_adr1", log_adr[1], 32'h500);
    check("prio_error", {31'd0, error}, 32'd1);
    check("prio_words", {16'd0, words_written}, 32'd1);

    // Abort during the write of word 1.
    clear_all();
    load_fifo(32'h90, 8);
    pulse_start(32'h600, 8, t0);
    begin
      int k = 0;
      while (rise_t.size() < 2 && k < 100) begin step(); k++; end
      check("abort_reach", 32'(rise_t.size()), 32'd2);
    end
    abort = 1'b1;
    wait_done("abort", 100);
    abort = 1'b0;
    check("abort_words", {16'd0, words_written}, 32'd2);
    check("abort_pops", 32'(n_rd), 32'd2);
    check("abort_ndone", 32'(n_done), 32'd1);
    check("abort_error", {31'd0, error}, 32'd0);

    // Reset in the middle of a write.
    clear_all();
    load_fifo(32'h33, 4);
    pulse_start(32'h700, 4, t0);
    begin
      int k = 0;
      while (!wb_cyc_o && k < 50) begin step(); k++; end
      check("rstmid_reach", {31'd0, wb_cyc_o}, 32'd1);
    end
    wb_rst = 1'b1;
    step();
    check("rstmid_cyc", {31'd0, wb_cyc_o}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    wb_rst = 1'b0;
    repeat (5) step();
    check("rstmid_nodone", 32'(n_done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
